// File: rtl/aes_key_expander_pkg.sv
// Shared AES types, round constants and the forward S-box used by the key schedule.
package aes_key_expander_pkg;

   typedef logic [7:0]   byte_t;
   typedef byte_t [0:3]  word_t;
   typedef byte_t [0:15] round_key_t;

   typedef enum logic [1:0] {StIdle, StEmit, StSub} key_exp_state_e;

   localparam byte_t RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   // Indexed as SBOX[high nibble][low nibble].
   localparam byte_t SBOX [0:15][0:15] = '{
      '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76},
      '{8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0},
      '{8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15},
      '{8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75},
      '{8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84},
      '{8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf},
      '{8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8},
      '{8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2},
      '{8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73},
      '{8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb},
      '{8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79},
      '{8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08},
      '{8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a},
      '{8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e},
      '{8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf},
      '{8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16}
   };

   // One schedule step given SubWord(RotWord(w3)) already computed.
   function automatic round_key_t key_step(round_key_t key, word_t sub, byte_t rc);
      word_t temp;
      word_t w0;
      word_t w1;
      word_t w2;
      word_t w3;
      temp = sub ^ {rc, 24'h000000};
      w0   = key[0:3] ^ temp;
      w1   = key[4:7] ^ w0;
      w2   = key[8:11] ^ w1;
      w3   = key[12:15] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_key_expander_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
   import aes_key_expander_pkg::*;
(
   input  word_t word_i,
   output word_t word_o
);

   for (genvar i = 0; i < 4; i++) begin : g_byte
      assign word_o[i] = SBOX[word_i[i][7:4]][word_i[i][3:0]];
   end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule streaming round keys 0..10 over valid/ready.
// AES_KEYEXP_SBOX_REG_EN inserts a SUB cycle that registers the SubWord result.
module aes_key_expander
   import aes_key_expander_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned ROUND_W    = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               key_valid,
   output logic               key_ready,
   input  round_key_t         key_in,
   input  logic               flush,
   output logic               rk_valid,
   input  logic               rk_ready,
   output logic [ROUND_W-1:0] rk_round,
   output round_key_t         rk_key,
   output logic               busy,
   output logic               done
);

   if (NUM_ROUNDS != 10) begin : g_bad_rounds
      $error("aes_key_expander supports only NUM_ROUNDS = 10 (AES-128)");
   end

   localparam logic [ROUND_W-1:0] LastRound = ROUND_W'(NUM_ROUNDS);

   key_exp_state_e     state_q, state_d;
   round_key_t         key_q, key_d;
   logic [ROUND_W-1:0] round_q, round_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
`ifdef AES_KEYEXP_SBOX_REG_EN
   word_t              sub_q, sub_d;
`endif

   word_t rot_w;
   word_t sub_w;
   byte_t rcon_w;

   assign rot_w  = {key_q[13], key_q[14], key_q[15], key_q[12]};
   // Only consumed while round_q < LastRound, so the guard merely avoids an out-of-range read.
   assign rcon_w = (round_q < LastRound) ? RCON[round_q] : 8'h00;

   aes_sub_word u_sub_word (
      .word_i (rot_w),
      .word_o (sub_w)
   );

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      valid_d = valid_q;
      done_d  = 1'b0;
`ifdef AES_KEYEXP_SBOX_REG_EN
      sub_d   = sub_q;
`endif
      if (flush) begin
         state_d = StIdle;
         valid_d = 1'b0;
         round_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (key_valid) begin
                  key_d   = key_in;
                  round_d = '0;
                  valid_d = 1'b1;
                  state_d = StEmit;
               end
            end
            StEmit: begin
               if (valid_q && rk_ready) begin
                  if (round_q == LastRound) begin
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end else begin
`ifdef AES_KEYEXP_SBOX_REG_EN
                     sub_d   = sub_w;
                     valid_d = 1'b0;
                     state_d = StSub;
`else
                     key_d   = key_step(key_q, sub_w, rcon_w);
                     round_d = round_q + ROUND_W'(1);
`endif
                  end
               end
            end
            StSub: begin
`ifdef AES_KEYEXP_SBOX_REG_EN
               key_d   = key_step(key_q, sub_q, rcon_w);
               round_d = round_q + ROUND_W'(1);
               valid_d = 1'b1;
               state_d = StEmit;
`else
               state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         key_q   <= '0;
         round_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef AES_KEYEXP_SBOX_REG_EN
         sub_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         valid_q <= valid_d;
         done_q  <= done_d;
`ifdef AES_KEYEXP_SBOX_REG_EN
         sub_q   <= sub_d;
`endif
      end
   end

   assign key_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign rk_valid  = valid_q;
   assign rk_round  = round_q;
   assign rk_key    = key_q;
   assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench: word-level FIPS-197 key schedule model with a GF(2^8)-derived S-box.
module tb_aes_key_expander;

`ifdef AES_KEYEXP_SBOX_REG_EN
   localparam bit SubReg = 1'b1;
`else
   localparam bit SubReg = 1'b0;
`endif

   localparam logic [127:0] KeyFips = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] KeySeq  = 128'h00010203_04050607_08090a0b_0c0d0e0f;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key_in;
   logic         flush;
   logic         rk_valid;
   logic         rk_ready;
   logic [3:0]   rk_round;
   logic [127:0] rk_key;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]   sbox_m [256];
   int           beats;
   int           r10_cycle;
   int           done_cnt;
   logic [127:0] rk1_seen;
   logic [127:0] rk10_seen;

   always #5 clock = ~clock;

   aes_key_expander #(
      .NUM_ROUNDS (10),
      .ROUND_W    (4)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_in    (key_in),
      .flush     (flush),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk_round  (rk_round),
      .rk_key    (rk_key),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // S-box = affine transform of the multiplicative inverse in GF(2^8).
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
   endfunction

   function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // Cycle-by-cycle rule checker: inputs/outputs captured at one falling edge predict the next.
   bit           have_prev = 1'b0;
   bit           model_active = 1'b0;
   bit           sub_pending = 1'b0;
   int           sub_round;
   logic [127:0] model_key;
   logic         p_kv, p_kr, p_flush, p_rv, p_rr;
   logic [3:0]   p_round;
   logic [127:0] p_rkkey, p_key;

   always @(negedge clock) begin
      if (!reset_n) begin
         chk("rst_key_ready", key_ready, 1);
         chk("rst_rk_valid", rk_valid, 0);
         chk("rst_rk_round", rk_round, 0);
         chk("rst_rk_key", rk_key, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         have_prev    = 1'b0;
         model_active = 1'b0;
         sub_pending  = 1'b0;
      end else begin
         if (have_prev) begin
            if (p_flush) begin
               chk("flush_valid", rk_valid, 0);
               chk("flush_round", rk_round, 0);
               chk("flush_done", done, 0);
               chk("flush_ready", key_ready, 1);
               chk("flush_key_kept", rk_key, p_rkkey);
               model_active = 1'b0;
               sub_pending  = 1'b0;
            end else if (sub_pending) begin
               chk("sub_next_valid", rk_valid, 1);
               chk("sub_next_round", rk_round, sub_round);
               chk("sub_next_done", done, 0);
               sub_pending = 1'b0;
            end else if (p_kv && p_kr) begin
               model_key    = p_key;
               model_active = 1'b1;
               chk("accept_valid", rk_valid, 1);
               chk("accept_round", rk_round, 0);
               chk("accept_key", rk_key, p_key);
               chk("accept_done", done, 0);
            end else if (p_rv && !p_rr) begin
               chk("stall_valid", rk_valid, 1);
               chk("stall_round", rk_round, p_round);
               chk("stall_key", rk_key, p_rkkey);
               chk("stall_done", done, 0);
            end else if (p_rv && p_rr) begin
               if (p_round == 4'd10) begin
                  chk("last_valid", rk_valid, 0);
                  chk("last_done", done, 1);
                  chk("last_ready", key_ready, 1);
                  model_active = 1'b0;
               end else begin
                  chk("beat_valid", rk_valid, !SubReg);
                  chk("beat_done", done, 0);
                  chk("beat_busy", busy, 1);
                  if (rk_valid) chk("beat_round", rk_round, p_round + 1);
                  if (SubReg) begin
                     sub_pending = 1'b1;
                     sub_round   = int'(p_round) + 1;
                  end
               end
            end else begin
               chk("quiet_valid", rk_valid, 0);
               chk("quiet_done", done, 0);
            end
         end
         chk("busy_vs_ready", busy, !key_ready);
         if (rk_valid) begin
            if (!model_active || rk_round > 4'd10) chk("unexpected_valid", rk_valid, 0);
            else chk("round_key", rk_key, round_key(model_key, int'(rk_round)));
         end
         have_prev = 1'b1;
         p_kv      = key_valid;
         p_kr      = key_ready;
         p_flush   = flush;
         p_rv      = rk_valid;
         p_rr      = rk_ready;
         p_round   = rk_round;
         p_rkkey   = rk_key;
         p_key     = key_in;
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic start_key(input logic [127:0] k);
      key_valid = 1'b1;
      key_in    = k;
      cyc();
      key_valid = 1'b0;
   endtask

   // Consume beats until done, with optional random stalls of at most 5 cycles.
   task automatic run(input bit rnd, input int budget);
      int lowrun;
      bit seen;
      lowrun    = 0;
      seen      = 1'b0;
      beats     = 0;
      r10_cycle = -1;
      done_cnt  = 0;
      for (int c = 0; c < budget && !seen; c++) begin
         if (rnd && lowrun < 5) rk_ready = 1'($urandom_range(0, 1));
         else rk_ready = 1'b1;
         lowrun = rk_ready ? 0 : lowrun + 1;
         if (rk_valid && rk_round == 4'd1) rk1_seen = rk_key;
         if (rk_valid && rk_round == 4'd10) begin
            rk10_seen = rk_key;
            if (r10_cycle < 0) r10_cycle = c;
         end
         if (rk_valid && rk_ready) beats++;
         cyc();
         if (done) begin
            seen = 1'b1;
            done_cnt++;
         end
      end
      chk("run_done_seen", seen, 1);
   endtask

   task automatic wait_round(input logic [3:0] r);
      for (int c = 0; c < 60 && !(rk_valid && rk_round == r); c++) cyc();
      chk("reach_round", rk_valid && rk_round == r, 1);
   endtask

   initial begin
      logic [127:0] key_b;
      build_sbox();
      reset_n   = 1'b0;
      key_valid = 1'b0;
      key_in    = '0;
      flush     = 1'b0;
      rk_ready  = 1'b0;

      chk("model_sbox_00", sbox_m[8'h00], 8'h63);
      chk("model_sbox_53", sbox_m[8'h53], 8'hed);
      chk("model_fips_r1", round_key(KeyFips, 1), 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
      chk("model_fips_r10", round_key(KeyFips, 10), 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
      chk("model_seq_r10", round_key(KeySeq, 10), 128'h13111d7f_e3944a17_f307a78b_4d2b30c5);

      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      cyc();

      // Back-to-back expansion of the FIPS-197 key.
      rk_ready = 1'b1;
      start_key(KeyFips);
      chk("t1_r0_valid", rk_valid, 1);
      chk("t1_r0_round", rk_round, 0);
      chk("t1_r0_key", rk_key, KeyFips);
      run(1'b0, 60);
      chk("t1_r1_key", rk1_seen, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
      chk("t1_r10_key", rk10_seen, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
      chk("t1_r10_cycle", r10_cycle, SubReg ? 20 : 10);
      chk("t1_beats", beats, 11);
      chk("t1_ready_after", key_ready, 1);
      cyc();
      chk("t1_done_pulse", done, 0);

      // Random back-pressure.
      start_key(KeyFips);
      run(1'b1, 400);
      chk("t2_beats", beats, 11);
      chk("t2_r10_key", rk10_seen, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

      // Flush while round 4 is presented, then a fresh key.
      rk_ready = 1'b1;
      start_key(KeyFips);
      wait_round(4'd4);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("t3_valid", rk_valid, 0);
      chk("t3_ready", key_ready, 1);
      chk("t3_done", done, 0);
      cyc();
      chk("t3_no_late_done", done, 0);
      start_key(KeySeq);
      run(1'b0, 60);
      chk("t3_r10_key", rk10_seen, 128'h13111d7f_e3944a17_f307a78b_4d2b30c5);

      // Asynchronous reset mid-expansion.
      start_key({$urandom(), $urandom(), $urandom(), $urandom()});
      wait_round(4'd7);
      #2 reset_n = 1'b0;
      #1;
      chk("t4_valid", rk_valid, 0);
      chk("t4_round", rk_round, 0);
      chk("t4_key", rk_key, 0);
      chk("t4_ready", key_ready, 1);
      chk("t4_busy", busy, 0);
      chk("t4_done", done, 0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t4_quiet", rk_valid, 0);
      end

      // Second key held during EMIT is taken only once the block is idle again.
      key_b     = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_valid = 1'b1;
      key_in    = KeyFips;
      cyc();
      key_in = key_b;
      run(1'b0, 60);
      chk("t5_ready_at_done", key_ready, 1);
      cyc();
      key_valid = 1'b0;
      chk("t5_b_valid", rk_valid, 1);
      chk("t5_b_round", rk_round, 0);
      chk("t5_b_key", rk_key, key_b);
      run(1'b0, 60);
      chk("t5_b_r10", rk10_seen, round_key(key_b, 10));

      // Fully random traffic, checked by the per-cycle process.
      for (int i = 0; i < 800; i++) begin
         key_valid = ($urandom_range(0, 3) == 0);
         key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
         rk_ready  = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         cyc();
      end
      key_valid = 1'b0;
      flush     = 1'b0;
      rk_ready  = 1'b1;
      repeat (30) cyc();
      chk("end_idle", key_ready, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
